// File: rtl/sar_search.sv
// sar_search: successive-approximation search engine.
//
// Recovers an unknown WIDTH-bit target that sits on the b side of an
// external unsigned magnitude comparator. The engine drives trial words
// on the comparator a side and rebuilds the target one bit per
// comparison, starting at the MSB. A comparison that reports eq ends the
// search early.
//
// Handshake: start is sampled only in IDLE. A start seen in that state
// is accepted on that clock edge. busy is then high until the result is
// final. done pulses for one cycle, and busy is low in that cycle. err,
// result and steps are valid from done and hold until the next accepted
// start. A start seen while busy or in the done cycle is dropped, not
// queued.
//
// Parameters:
//   WIDTH    probe/target width in bits
//   CMP_LAT  registered latency of the comparator path; 0 = combinational
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin a search (IDLE only)
//   probe      trial value to comparator a input (registered)
//   gt/lt/eq   comparator verdicts for probe vs target
//   busy       search in progress
//   done       one-cycle pulse, result final
//   err        flag protocol violation or target out of range
//   result     recovered target value
//   steps      number of comparisons consumed
//   state_dbg  current FSM state for observation
module sar_search #(
    parameter int WIDTH   = 16,
    parameter int CMP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] probe,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       steps,
    output logic [2:0]       state_dbg
);

    localparam int IW = $clog2(WIDTH);
    // The wait counter holds at most CMP_LAT-1. Keep it at least one bit
    // wide so that it is still legal when CMP_LAT is 0 or 1.
    localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SET  = 3'd1,
        S_WAIT = 3'd2,
        S_EVAL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] probe_n, result_n;
    logic [4:0]       steps_n;
    logic             err_n;
    logic [IW-1:0]    idx, idx_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             flags_ok;
    logic [WIDTH-1:0] bit_mask;

    // The XOR is true when one or three flags are high. Clearing the
    // all-three case leaves exactly-one-hot.
    assign flags_ok = (gt ^ lt ^ eq) && !(gt && lt && eq);
    assign bit_mask = WIDTH'(1) << idx;

    always_comb begin
        state_n  = state;
        probe_n  = probe;
        result_n = result;
        steps_n  = steps;
        err_n    = err;
        idx_n    = idx;
        cnt_n    = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    result_n = '0;
                    steps_n  = '0;
                    err_n    = 1'b0;
                    idx_n    = IW'(WIDTH - 1);
                    state_n  = S_SET;
                end
            end
            S_SET: begin
                probe_n = result | bit_mask;
                cnt_n   = CW'(CMP_LAT - 1);
                state_n = (CMP_LAT > 0) ? S_WAIT : S_EVAL;
            end
            S_WAIT: begin
                // probe is held here so the comparator pipeline can settle.
                if (cnt == '0) begin
                    state_n = S_EVAL;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_EVAL: begin
                steps_n = steps + 5'd1;
                if (!flags_ok) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else if (eq) begin
                    result_n = probe;
                    state_n  = S_DONE;
                end else begin
                    if (lt) begin
                        result_n = result | bit_mask;
                    end
                    if (idx == '0) begin
                        // lt on the last bit means the target lies above
                        // every value that WIDTH bits can represent.
                        if (lt) begin
                            err_n = 1'b1;
                        end
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx - IW'(1);
                        state_n = S_SET;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            probe  <= '0;
            result <= '0;
            steps  <= '0;
            err    <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            probe  <= probe_n;
            result <= result_n;
            steps  <= steps_n;
            err    <= err_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
        end
    end

    assign busy      = (state == S_SET) || (state == S_WAIT) || (state == S_EVAL);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search. Two instances are used: u0 has a combinational
// comparator (CMP_LAT=0) and u1 has a registered comparator (CMP_LAT=1).
// Expected results come from closed-form rules. The search for target t
// ends on eq at bit ctz(t), so it takes 16-ctz(t) steps and gives
// result t. The probe for step j holds the bits of t above bit k=16-j,
// and bit k is set.
module tb_sar_search;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [15:0] probe0, probe1, result0, result1;
    logic        gt0, lt0, eq0, gt1, lt1, eq1;
    logic        busy0, busy1, done0, done1, err0, err1;
    logic [4:0]  steps0, steps1;
    logic [2:0]  st0, st1;
    logic [15:0] target0, target1;
    logic        rg1, rl1, re1;
    int          inj;
    logic [2:0]  noise;
    int          sel;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] c_probe, c_result;
    logic [4:0]  c_steps;
    logic        c_busy, c_done, c_err;

    always #5 clk = ~clk;

    sar_search #(.WIDTH(16), .CMP_LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .probe(probe0),
        .gt(gt0), .lt(lt0), .eq(eq0), .busy(busy0), .done(done0),
        .err(err0), .result(result0), .steps(steps0), .state_dbg(st0)
    );

    sar_search #(.WIDTH(16), .CMP_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .probe(probe1),
        .gt(gt1), .lt(lt1), .eq(eq1), .busy(busy1), .done(done1),
        .err(err1), .result(result1), .steps(steps1), .state_dbg(st1)
    );

    // Comparator for u0 (combinational), with fault and noise overrides.
    always_comb begin
        gt0 = probe0 > target0;
        lt0 = probe0 < target0;
        eq0 = probe0 == target0;
        case (inj)
            1: begin gt0 = 1'b1; lt0 = 1'b1; eq0 = 1'b0; end
            2: begin gt0 = 1'b0; lt0 = 1'b1; eq0 = 1'b0; end
            3: {gt0, lt0, eq0} = noise;
            default: ;
        endcase
    end

    // Comparator for u1, with one register stage.
    always @(posedge clk) begin
        rg1 <= probe1 > target1;
        rl1 <= probe1 < target1;
        re1 <= probe1 == target1;
    end

    always_comb begin
        gt1 = rg1;
        lt1 = rl1;
        eq1 = re1;
        case (inj)
            1: begin gt1 = 1'b1; lt1 = 1'b1; eq1 = 1'b0; end
            2: begin gt1 = 1'b0; lt1 = 1'b1; eq1 = 1'b0; end
            3: {gt1, lt1, eq1} = noise;
            default: ;
        endcase
    end

    always_comb begin
        c_probe  = (sel != 0) ? probe1  : probe0;
        c_result = (sel != 0) ? result1 : result0;
        c_steps  = (sel != 0) ? steps1  : steps0;
        c_busy   = (sel != 0) ? busy1   : busy0;
        c_done   = (sel != 0) ? done1   : done0;
        c_err    = (sel != 0) ? err1    : err0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ctz16(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 16;
    endfunction

    // Probe at step j (1-based). Mode 2 forces lt at every step, so all
    // bits at or above the current bit are set.
    function automatic logic [15:0] exp_probe(input logic [15:0] t, input int j, input int mode);
        logic [15:0] bit_k, low_m;
        bit_k = 16'd1 << (16 - j);
        low_m = (bit_k << 1) - 16'd1;
        if (mode == 2) return ~(bit_k - 16'd1);
        return (t & ~low_m) | bit_k;
    endfunction

    // mode: 0 clean, 1 gt&lt on third EVAL, 2 lt forced always,
    //       3 random flag noise outside EVAL cycles.
    // bs: cycle after acceptance on which to pulse start (0 none, -1 done cycle).
    task automatic run_search(input int s, input logic [15:0] t, input int mode, input int bs);
        int per, exp_steps, exp_done, busy_at, j;
        logic [15:0] exp_res, last_probe;
        logic        exp_err;
        sel = s;
        per = (s != 0) ? 3 : 2;
        if (s != 0) target1 = t; else target0 = t;
        case (mode)
            1: begin exp_steps = 3;  exp_res = t & 16'hC000; exp_err = 1'b1; end
            2: begin exp_steps = 16; exp_res = 16'hFFFF;     exp_err = 1'b1; end
            default: begin
                exp_steps = (t == 16'd0) ? 16 : 16 - ctz16(t);
                exp_res   = t;
                exp_err   = 1'b0;
            end
        endcase
        exp_done   = per * exp_steps + 1;
        busy_at    = (bs < 0) ? exp_done : bs;
        last_probe = exp_probe(t, exp_steps, mode);

        @(negedge clk);
        if (s != 0) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        for (int n = 1; n <= exp_done; n++) begin
            if (n > 1) @(negedge clk);
            inj = 0;
            if (mode == 2) inj = 2;
            else if (mode == 1 && n == per * 3) inj = 1;
            else if (mode == 3 && (n % per) != 0 && n < exp_done) begin
                inj   = 3;
                noise = 3'($urandom_range(0, 7));
            end
            if (s != 0) start1 = (n == busy_at); else start0 = (n == busy_at);
            if (n < exp_done) begin
                check("busy", 32'(c_busy), 1);
                check("done_early", 32'(c_done), 0);
                if (((n - 1) % per) != 0) begin
                    j = (n + per - 1) / per;
                    check($sformatf("probe_t%0h_s%0d", t, j), 32'(c_probe), 32'(exp_probe(t, j, mode)));
                end
            end else begin
                check($sformatf("done_t%0h", t), 32'(c_done), 1);
                check("busy_at_done", 32'(c_busy), 0);
                check($sformatf("result_t%0h", t), 32'(c_result), 32'(exp_res));
                check($sformatf("steps_t%0h", t), 32'(c_steps), 32'(exp_steps));
                check($sformatf("err_t%0h", t), 32'(c_err), 32'(exp_err));
                check("probe_last", 32'(c_probe), 32'(last_probe));
            end
        end
        @(negedge clk);
        inj    = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        check("done_pulse_len", 32'(c_done), 0);
        check("busy_after", 32'(c_busy), 0);
        check("result_hold", 32'(c_result), 32'(exp_res));
        check("steps_hold", 32'(c_steps), 32'(exp_steps));
        check("err_hold", 32'(c_err), 32'(exp_err));
        check("probe_hold", 32'(c_probe), 32'(last_probe));
        @(negedge clk);
        check("idle_busy", 32'(c_busy), 0);
        check("idle_done", 32'(c_done), 0);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_probe"},  32'(probe0),  0);
        check({tag, "_busy"},   32'(busy0),   0);
        check({tag, "_done"},   32'(done0),   0);
        check({tag, "_err"},    32'(err0),    0);
        check({tag, "_result"}, 32'(result0), 0);
        check({tag, "_steps"},  32'(steps0),  0);
    endtask

    task automatic reset_mid(input logic [15:0] t);
        sel     = 0;
        target0 = t | 16'h0001;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            if (n > 1) @(negedge clk);
            check("rstmid_done", 32'(done0), 0);
            if (n == 5) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check_zero0("rstmid");
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("rstmid_no_done", 32'(done0), 0);
            check("rstmid_idle", 32'(busy0), 0);
        end
    endtask

    initial begin
        logic [15:0] r;
        rst     = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        inj     = 0;
        noise   = 3'd0;
        sel     = 0;
        target0 = 16'd0;
        target1 = 16'd0;
        repeat (3) @(negedge clk);
        check_zero0("reset");
        check("reset_u1_probe", 32'(probe1), 0);
        check("reset_u1_busy", 32'(busy1), 0);
        check("reset_u1_done", 32'(done1), 0);
        check("reset_u1_result", 32'(result1), 0);
        check("reset_u1_steps", 32'(steps1), 0);
        rst = 1'b0;
        @(negedge clk);

        run_search(0, 16'h0000, 0, 0);
        run_search(0, 16'h8000, 0, 0);
        run_search(0, 16'hFFFF, 0, 0);
        run_search(1, 16'h1234, 0, 0);
        run_search(1, 16'hFFFF, 0, 0);

        r = 16'($urandom_range(0, 65535));
        run_search(0, r | 16'h0001, 1, 0);
        r = 16'($urandom_range(0, 65535));
        run_search(0, r, 2, 0);

        reset_mid(16'($urandom_range(0, 65535)));
        run_search(0, 16'($urandom_range(0, 65535)), 0, 3);
        run_search(0, 16'($urandom_range(0, 65535)), 0, -1);

        // rst and start together: rst wins, start is not accepted.
        @(negedge clk);
        rst    = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start0 = 1'b0;
        check_zero0("rst_prio");
        @(negedge clk);
        check("rst_prio_idle", 32'(busy0), 0);

        for (int i = 0; i < 8; i++) begin
            r = 16'($urandom_range(0, 65535));
            if (i == 3) r = r & 16'hFF00;
            run_search(int'($urandom_range(0, 1)), r, 3, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
